// File: rtl/reg_if_axil.sv
// Simple register request/ack interface bridged onto an AXI-lite master.
// Independent write (AW+W -> B) and read (AR -> R) state machines; acks are one-cycle pulses.
module reg_if_axil #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic [ADDR_WIDTH-1:0] reg_wr_addr,
  input  logic [DATA_WIDTH-1:0] reg_wr_data,
  input  logic [STRB_WIDTH-1:0] reg_wr_strb,
  input  logic                  reg_wr_en,
  output logic                  reg_wr_wait,
  output logic                  reg_wr_ack,
  input  logic [ADDR_WIDTH-1:0] reg_rd_addr,
  input  logic                  reg_rd_en,
  output logic [DATA_WIDTH-1:0] reg_rd_data,
  output logic                  reg_rd_wait,
  output logic                  reg_rd_ack,

  output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
  output logic [2:0]            m_axil_awprot,
  output logic                  m_axil_awvalid,
  input  logic                  m_axil_awready,
  output logic [DATA_WIDTH-1:0] m_axil_wdata,
  output logic [STRB_WIDTH-1:0] m_axil_wstrb,
  output logic                  m_axil_wvalid,
  input  logic                  m_axil_wready,
  input  logic [1:0]            m_axil_bresp,
  input  logic                  m_axil_bvalid,
  output logic                  m_axil_bready,
  output logic [ADDR_WIDTH-1:0] m_axil_araddr,
  output logic [2:0]            m_axil_arprot,
  output logic                  m_axil_arvalid,
  input  logic                  m_axil_arready,
  input  logic [DATA_WIDTH-1:0] m_axil_rdata,
  input  logic [1:0]            m_axil_rresp,
  input  logic                  m_axil_rvalid,
  output logic                  m_axil_rready
);

  typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_RESP} state_t;

  state_t                wr_state_q, wr_state_d;
  logic                  awvalid_q, awvalid_d;
  logic                  wvalid_q, wvalid_d;
  logic                  bready_q, bready_d;
  logic                  wr_ack_q, wr_ack_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic [STRB_WIDTH-1:0] wr_strb_q, wr_strb_d;

  state_t                rd_state_q, rd_state_d;
  logic                  arvalid_q, arvalid_d;
  logic                  rready_q, rready_d;
  logic                  rd_ack_q, rd_ack_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;

  // Response codes are deliberately not acted upon.
  logic unused_resp;
  assign unused_resp = ^{m_axil_bresp, m_axil_rresp};

  always_comb begin
    wr_state_d = wr_state_q;
    awvalid_d  = awvalid_q;
    wvalid_d   = wvalid_q;
    bready_d   = bready_q;
    wr_ack_d   = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    wr_strb_d  = wr_strb_q;
    case (wr_state_q)
      ST_IDLE: begin
        // The ack cycle masks en so a held request is not double-issued.
        if (reg_wr_en && !wr_ack_q) begin
          wr_addr_d  = reg_wr_addr;
          wr_data_d  = reg_wr_data;
          wr_strb_d  = reg_wr_strb;
          awvalid_d  = 1'b1;
          wvalid_d   = 1'b1;
          wr_state_d = ST_ADDR;
        end
      end
      ST_ADDR: begin
        awvalid_d = awvalid_q && !m_axil_awready;
        wvalid_d  = wvalid_q && !m_axil_wready;
        if (!awvalid_d && !wvalid_d) begin
          bready_d   = 1'b1;
          wr_state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (m_axil_bvalid) begin
          bready_d   = 1'b0;
          wr_ack_d   = 1'b1;
          wr_state_d = ST_IDLE;
        end
      end
      default: begin
        awvalid_d  = 1'b0;
        wvalid_d   = 1'b0;
        bready_d   = 1'b0;
        wr_state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    rd_state_d = rd_state_q;
    arvalid_d  = arvalid_q;
    rready_d   = rready_q;
    rd_ack_d   = 1'b0;
    rd_addr_d  = rd_addr_q;
    rd_data_d  = rd_data_q;
    case (rd_state_q)
      ST_IDLE: begin
        if (reg_rd_en && !rd_ack_q) begin
          rd_addr_d  = reg_rd_addr;
          arvalid_d  = 1'b1;
          rd_state_d = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (m_axil_arready) begin
          arvalid_d  = 1'b0;
          rready_d   = 1'b1;
          rd_state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (m_axil_rvalid) begin
          rd_data_d  = m_axil_rdata;
          rready_d   = 1'b0;
          rd_ack_d   = 1'b1;
          rd_state_d = ST_IDLE;
        end
      end
      default: begin
        arvalid_d  = 1'b0;
        rready_d   = 1'b0;
        rd_state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_state_q <= ST_IDLE;
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
      bready_q   <= 1'b0;
      wr_ack_q   <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      wr_strb_q  <= '0;
      rd_state_q <= ST_IDLE;
      arvalid_q  <= 1'b0;
      rready_q   <= 1'b0;
      rd_ack_q   <= 1'b0;
      rd_addr_q  <= '0;
      rd_data_q  <= '0;
    end else begin
      wr_state_q <= wr_state_d;
      awvalid_q  <= awvalid_d;
      wvalid_q   <= wvalid_d;
      bready_q   <= bready_d;
      wr_ack_q   <= wr_ack_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      wr_strb_q  <= wr_strb_d;
      rd_state_q <= rd_state_d;
      arvalid_q  <= arvalid_d;
      rready_q   <= rready_d;
      rd_ack_q   <= rd_ack_d;
      rd_addr_q  <= rd_addr_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign reg_wr_wait    = (wr_state_q != ST_IDLE);
  assign reg_wr_ack     = wr_ack_q;
  assign reg_rd_wait    = (rd_state_q != ST_IDLE);
  assign reg_rd_ack     = rd_ack_q;
  assign reg_rd_data    = rd_data_q;

  assign m_axil_awaddr  = wr_addr_q;
  assign m_axil_awprot  = 3'b010;
  assign m_axil_awvalid = awvalid_q;
  assign m_axil_wdata   = wr_data_q;
  assign m_axil_wstrb   = wr_strb_q;
  assign m_axil_wvalid  = wvalid_q;
  assign m_axil_bready  = bready_q;
  assign m_axil_araddr  = rd_addr_q;
  assign m_axil_arprot  = 3'b010;
  assign m_axil_arvalid = arvalid_q;
  assign m_axil_rready  = rready_q;

endmodule

// File: tb/tb_reg_if_axil.sv
// Directed bench for reg_if_axil: latency, split AW/W handshakes, stalled read,
// back-to-back held requests, and async reset mid-transaction.
module tb_reg_if_axil;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] reg_wr_addr, reg_wr_data, reg_rd_addr, reg_rd_data;
  logic [3:0]  reg_wr_strb;
  logic        reg_wr_en, reg_wr_wait, reg_wr_ack;
  logic        reg_rd_en, reg_rd_wait, reg_rd_ack;
  logic [31:0] m_axil_awaddr, m_axil_wdata, m_axil_araddr, m_axil_rdata;
  logic [2:0]  m_axil_awprot, m_axil_arprot;
  logic [3:0]  m_axil_wstrb;
  logic        m_axil_awvalid, m_axil_awready, m_axil_wvalid, m_axil_wready;
  logic [1:0]  m_axil_bresp, m_axil_rresp;
  logic        m_axil_bvalid, m_axil_bready, m_axil_arvalid, m_axil_arready;
  logic        m_axil_rvalid, m_axil_rready;

  int n_vec = 0;
  int n_err = 0;
  int aw_hs = 0, w_hs = 0, wr_acks = 0, rd_acks = 0;
  int a0, w0, k0, r0;

  always #5 clk = ~clk;

  reg_if_axil dut (
    .clk(clk), .rst(rst),
    .reg_wr_addr(reg_wr_addr), .reg_wr_data(reg_wr_data), .reg_wr_strb(reg_wr_strb),
    .reg_wr_en(reg_wr_en), .reg_wr_wait(reg_wr_wait), .reg_wr_ack(reg_wr_ack),
    .reg_rd_addr(reg_rd_addr), .reg_rd_en(reg_rd_en), .reg_rd_data(reg_rd_data),
    .reg_rd_wait(reg_rd_wait), .reg_rd_ack(reg_rd_ack),
    .m_axil_awaddr(m_axil_awaddr), .m_axil_awprot(m_axil_awprot),
    .m_axil_awvalid(m_axil_awvalid), .m_axil_awready(m_axil_awready),
    .m_axil_wdata(m_axil_wdata), .m_axil_wstrb(m_axil_wstrb),
    .m_axil_wvalid(m_axil_wvalid), .m_axil_wready(m_axil_wready),
    .m_axil_bresp(m_axil_bresp), .m_axil_bvalid(m_axil_bvalid), .m_axil_bready(m_axil_bready),
    .m_axil_araddr(m_axil_araddr), .m_axil_arprot(m_axil_arprot),
    .m_axil_arvalid(m_axil_arvalid), .m_axil_arready(m_axil_arready),
    .m_axil_rdata(m_axil_rdata), .m_axil_rresp(m_axil_rresp),
    .m_axil_rvalid(m_axil_rvalid), .m_axil_rready(m_axil_rready)
  );

  // Handshake/ack counters, sampled mid-cycle when everything is stable.
  always @(negedge clk) begin
    if (!rst) begin
      if (m_axil_awvalid && m_axil_awready) aw_hs++;
      if (m_axil_wvalid && m_axil_wready) w_hs++;
      if (reg_wr_ack) wr_acks++;
      if (reg_rd_ack) rd_acks++;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    reg_wr_addr = '0; reg_wr_data = '0; reg_wr_strb = '0; reg_wr_en = 1'b0;
    reg_rd_addr = '0; reg_rd_en = 1'b0;
    m_axil_awready = 1'b0; m_axil_wready = 1'b0; m_axil_bresp = 2'b00; m_axil_bvalid = 1'b0;
    m_axil_arready = 1'b0; m_axil_rdata = '0; m_axil_rresp = 2'b00; m_axil_rvalid = 1'b0;

    // Reset state
    repeat (2) smp();
    chk("rst_awvalid", m_axil_awvalid, 0);
    chk("rst_wvalid", m_axil_wvalid, 0);
    chk("rst_bready", m_axil_bready, 0);
    chk("rst_arvalid", m_axil_arvalid, 0);
    chk("rst_rready", m_axil_rready, 0);
    chk("rst_waits", {reg_wr_wait, reg_rd_wait, reg_wr_ack, reg_rd_ack}, 0);
    chk("rst_rd_data", reg_rd_data, 0);
    chk("rst_awaddr", m_axil_awaddr, 0);
    nxt(); rst = 1'b0;

    // Minimum-latency write
    nxt();
    reg_wr_addr = 32'h10; reg_wr_data = 32'hDEADBEEF; reg_wr_strb = 4'hF; reg_wr_en = 1'b1;
    m_axil_awready = 1'b1; m_axil_wready = 1'b1; m_axil_bvalid = 1'b1;
    smp();
    chk("t1_c0_awvalid", m_axil_awvalid, 0);
    chk("t1_c0_wait", reg_wr_wait, 0);
    nxt(); smp();
    chk("t1_c1_awvalid", m_axil_awvalid, 1);
    chk("t1_c1_wvalid", m_axil_wvalid, 1);
    chk("t1_c1_awaddr", m_axil_awaddr, 32'h10);
    chk("t1_c1_wdata", m_axil_wdata, 32'hDEADBEEF);
    chk("t1_c1_wstrb", m_axil_wstrb, 4'hF);
    chk("t1_c1_awprot", m_axil_awprot, 3'b010);
    chk("t1_c1_wait", reg_wr_wait, 1);
    chk("t1_c1_bready", m_axil_bready, 0);
    nxt(); smp();
    chk("t1_c2_valids", {m_axil_awvalid, m_axil_wvalid}, 2'b00);
    chk("t1_c2_bready", m_axil_bready, 1);
    chk("t1_c2_ack", reg_wr_ack, 0);
    nxt(); reg_wr_en = 1'b0; smp();
    chk("t1_c3_ack", reg_wr_ack, 1);
    chk("t1_c3_bready", m_axil_bready, 0);
    chk("t1_c3_wait", reg_wr_wait, 0);
    nxt(); smp();
    chk("t1_c4_ack", reg_wr_ack, 0);
    chk("t1_c4_awvalid", m_axil_awvalid, 0);

    // W completes three cycles ahead of AW
    nxt();
    a0 = aw_hs; w0 = w_hs; k0 = wr_acks;
    reg_wr_addr = 32'h14; reg_wr_data = 32'hA5A5A5A5; reg_wr_strb = 4'h3; reg_wr_en = 1'b1;
    m_axil_awready = 1'b0; m_axil_wready = 1'b1;
    smp();
    nxt(); smp();
    chk("t2_c1_valids", {m_axil_awvalid, m_axil_wvalid}, 2'b11);
    chk("t2_c1_wait", reg_wr_wait, 1);
    nxt(); reg_wr_addr = 32'hFFFF_FFFF; reg_wr_data = 32'h0; smp();
    chk("t2_c2_valids", {m_axil_awvalid, m_axil_wvalid}, 2'b10);
    chk("t2_c2_awaddr", m_axil_awaddr, 32'h14);
    chk("t2_c2_wdata", m_axil_wdata, 32'hA5A5A5A5);
    chk("t2_c2_wait", reg_wr_wait, 1);
    nxt(); smp();
    chk("t2_c3_valids", {m_axil_awvalid, m_axil_wvalid}, 2'b10);
    chk("t2_c3_bready", m_axil_bready, 0);
    chk("t2_c3_wait", reg_wr_wait, 1);
    nxt(); m_axil_awready = 1'b1; smp();
    chk("t2_c4_awvalid", m_axil_awvalid, 1);
    chk("t2_c4_wait", reg_wr_wait, 1);
    nxt(); smp();
    chk("t2_c5_awvalid", m_axil_awvalid, 0);
    chk("t2_c5_bready", m_axil_bready, 1);
    chk("t2_c5_wait", reg_wr_wait, 1);
    nxt(); reg_wr_en = 1'b0; smp();
    chk("t2_c6_ack", reg_wr_ack, 1);
    nxt(); smp();
    chk("t2_c7_ack", reg_wr_ack, 0);
    nxt();
    chk("t2_aw_count", aw_hs - a0, 1);
    chk("t2_w_count", w_hs - w0, 1);
    chk("t2_ack_count", wr_acks - k0, 1);

    // Read with five stall cycles and an error response
    r0 = rd_acks;
    reg_rd_addr = 32'h20; reg_rd_en = 1'b1; m_axil_arready = 1'b1; m_axil_rvalid = 1'b0;
    smp();
    nxt(); smp();
    chk("t3_c1_arvalid", m_axil_arvalid, 1);
    chk("t3_c1_araddr", m_axil_araddr, 32'h20);
    chk("t3_c1_arprot", m_axil_arprot, 3'b010);
    chk("t3_c1_wait", reg_rd_wait, 1);
    nxt(); smp();
    chk("t3_c2_arvalid", m_axil_arvalid, 0);
    chk("t3_c2_rready", m_axil_rready, 1);
    for (int i = 0; i < 4; i++) begin
      nxt(); smp();
      chk("t3_stall_rready", m_axil_rready, 1);
      chk("t3_stall_ack", reg_rd_ack, 0);
    end
    nxt(); m_axil_rvalid = 1'b1; m_axil_rdata = 32'h12345678; m_axil_rresp = 2'b10; smp();
    chk("t3_c7_rd_data_old", reg_rd_data, 0);
    nxt();
    reg_rd_en = 1'b0; m_axil_rvalid = 1'b0; m_axil_rdata = 32'hFFFF_FFFF; m_axil_rresp = 2'b00;
    smp();
    chk("t3_c8_ack", reg_rd_ack, 1);
    chk("t3_c8_rd_data", reg_rd_data, 32'h12345678);
    chk("t3_c8_rready", m_axil_rready, 0);
    chk("t3_c8_wait", reg_rd_wait, 0);
    nxt(); smp();
    chk("t3_c9_ack", reg_rd_ack, 0);
    chk("t3_c9_rd_data", reg_rd_data, 32'h12345678);
    nxt(); smp();
    chk("t3_c10_rd_data", reg_rd_data, 32'h12345678);
    nxt();
    chk("t3_ack_count", rd_acks - r0, 1);

    // Concurrent held requests give back-to-back transactions on both paths
    k0 = wr_acks; r0 = rd_acks;
    reg_wr_addr = 32'h4; reg_wr_data = 32'h11112222; reg_wr_strb = 4'hF; reg_wr_en = 1'b1;
    reg_rd_addr = 32'h8; reg_rd_en = 1'b1;
    m_axil_awready = 1'b1; m_axil_wready = 1'b1; m_axil_bvalid = 1'b1;
    m_axil_arready = 1'b1; m_axil_rvalid = 1'b1; m_axil_rdata = 32'hCAFEF00D;
    smp();
    nxt(); smp();
    chk("t4_c1_valids", {m_axil_awvalid, m_axil_wvalid, m_axil_arvalid}, 3'b111);
    nxt(); smp();
    chk("t4_c2_readies", {m_axil_bready, m_axil_rready}, 2'b11);
    nxt(); smp();
    chk("t4_c3_acks", {reg_wr_ack, reg_rd_ack}, 2'b11);
    chk("t4_c3_rd_data", reg_rd_data, 32'hCAFEF00D);
    nxt(); m_axil_rdata = 32'h0BADBEEF; smp();
    chk("t4_c4_acks", {reg_wr_ack, reg_rd_ack}, 2'b00);
    chk("t4_c4_waits", {reg_wr_wait, reg_rd_wait}, 2'b00);
    chk("t4_c4_valids", {m_axil_awvalid, m_axil_arvalid}, 2'b00);
    nxt(); smp();
    chk("t4_c5_valids", {m_axil_awvalid, m_axil_wvalid, m_axil_arvalid}, 3'b111);
    chk("t4_c5_awaddr", m_axil_awaddr, 32'h4);
    chk("t4_c5_araddr", m_axil_araddr, 32'h8);
    nxt(); smp();
    nxt(); reg_wr_en = 1'b0; reg_rd_en = 1'b0; smp();
    chk("t4_c7_acks", {reg_wr_ack, reg_rd_ack}, 2'b11);
    chk("t4_c7_rd_data", reg_rd_data, 32'h0BADBEEF);
    nxt(); smp();
    chk("t4_c8_acks", {reg_wr_ack, reg_rd_ack}, 2'b00);
    chk("t4_c8_waits", {reg_wr_wait, reg_rd_wait}, 2'b00);
    chk("t4_c8_valids", {m_axil_awvalid, m_axil_arvalid}, 2'b00);
    nxt();
    chk("t4_wr_ack_count", wr_acks - k0, 2);
    chk("t4_rd_ack_count", rd_acks - r0, 2);

    // Reset while waiting for B abandons the write
    k0 = wr_acks;
    reg_wr_addr = 32'h30; reg_wr_data = 32'h77; reg_wr_strb = 4'hF; reg_wr_en = 1'b1;
    m_axil_bvalid = 1'b0;
    smp();
    nxt(); smp();
    nxt(); smp();
    chk("t5_c2_bready", m_axil_bready, 1);
    chk("t5_c2_wait", reg_wr_wait, 1);
    #1 rst = 1'b1;
    #1;
    chk("t5_rst_bready", m_axil_bready, 0);
    chk("t5_rst_wait", reg_wr_wait, 0);
    chk("t5_rst_rd_data", reg_rd_data, 0);
    chk("t5_rst_awaddr", m_axil_awaddr, 0);
    nxt(); reg_wr_en = 1'b0; m_axil_bvalid = 1'b1; smp();
    nxt(); rst = 1'b0; smp();
    chk("t5_post_ack", reg_wr_ack, 0);
    chk("t5_post_wait", reg_wr_wait, 0);
    nxt(); smp();
    nxt();
    chk("t5_no_ack", wr_acks - k0, 0);
    reg_wr_addr = 32'h34; reg_wr_data = 32'h5; reg_wr_strb = 4'h1; reg_wr_en = 1'b1;
    smp();
    nxt(); smp();
    chk("t5_new_awvalid", m_axil_awvalid, 1);
    chk("t5_new_awaddr", m_axil_awaddr, 32'h34);
    chk("t5_new_wstrb", m_axil_wstrb, 4'h1);
    nxt(); smp();
    chk("t5_new_bready", m_axil_bready, 1);
    nxt(); reg_wr_en = 1'b0; smp();
    chk("t5_new_ack", reg_wr_ack, 1);
    nxt(); smp();
    chk("t5_new_ack_end", reg_wr_ack, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
